// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the fetch/next-PC sequencer
package pc_seq_pkg;

    typedef enum logic [1:0] {
        RST,
        FETCH,
        EXEC,
        HALT
    } pc_state_t;

    typedef enum logic [2:0] {
        SEQ,
        REDIR,
        TRAP,
        MRET,
        HOLD
    } npc_sel_t;

    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/pc_reg.sv
// pc_reg: 32-bit program counter register with load enable
module pc_reg #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    logic [31:0] pc_q;

    // load a new PC only when the sequencer selects one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc_q <= RESET_ADDR;
        else if (en_i) pc_q <= d_i;
    end

    assign q_o = pc_q;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute FSM owning the PC, mepc and fetched instruction
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC   = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        trap,
    input  logic        mret,
    input  logic        halt,
    output logic [31:0] mepc,
    output logic        halted
);

    pc_state_t   state_q, state_d;
    npc_sel_t    sel;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_d;

    pc_reg #(.RESET_ADDR(RESET_ADDR)) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (sel != HOLD),
        .d_i   (pc_d),
        .q_o   (pc)
    );

    // state, saved trap PC and fetched instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RST;
            mepc_q  <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            mepc_q  <= mepc_d;
            instr_q <= instr_d;
        end
    end

    // next state plus next-PC source; misaligned redirect targets fall into the trap path
    always_comb begin
        state_d = state_q;
        sel     = HOLD;
        mepc_d  = mepc_q;
        instr_d = instr_q;
        case (state_q)
            RST:   state_d = FETCH;
            FETCH: if (imem_ack) begin
                instr_d = imem_rdata;
                state_d = EXEC;
            end
            EXEC: if (!stall) begin
                state_d = halt ? HALT : FETCH;
                if (halt) sel = HOLD;
                else if (trap || (!mret && redirect && redirect_target[1:0] != 2'b00)) begin
                    sel    = TRAP;
                    mepc_d = pc;
                end
                else if (mret) sel = MRET;
                else if (redirect) sel = REDIR;
                else sel = SEQ;
            end
            default: state_d = HALT;
        endcase
    end

    // next-PC mux
    always_comb begin
        case (sel)
            SEQ:     pc_d = pc + PC_INC;
            REDIR:   pc_d = redirect_target;
            TRAP:    pc_d = TRAP_VEC;
            MRET:    pc_d = mepc_q;
            default: pc_d = pc;
        endcase
    end

    assign imem_req    = state_q == FETCH;
    assign imem_addr   = pc;
    assign instr_valid = state_q == EXEC;
    assign halted      = state_q == HALT;
    assign instr       = instr_q;
    assign mepc        = mepc_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch/next-PC controller for the RISC-V core. It owns the program counter, issues one instruction-memory request per instruction over a req/ack handshake, and presents the fetched word to decode/execute. It selects the next PC from sequential, branch/jump redirect, trap-vector and `mret` sources, and supports stall and halt. It replaces the free-running PC update of the single-cycle datapath with a sequenced fetch–execute loop.

## Interface
Parameters:
- `RESET_ADDR`, 32'h0000_0000: PC loaded on reset.
- `TRAP_VEC`, 32'h0000_0100: PC loaded on trap entry.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  32  fetch address; equals `pc`.
- `imem_ack`  in  1  memory has returned `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  registered instruction presented to the core.
- `instr_valid`  out  1  `instr`/`pc` are valid; the core executes this cycle.
- `pc`  out  32  address of the current instruction.
- `stall`  in  1  core cannot retire; hold the current instruction.
- `redirect`  in  1  branch/jump taken.
- `redirect_target`  in  32  target of a taken branch/jump.
- `trap`  in  1  ecall/illegal instruction.
- `mret`  in  1  return from trap.
- `halt`  in  1  ebreak; stop fetching.
- `mepc`  out  32  saved PC of the trapping instruction.
- `halted`  out  1  sequencer is in HALT.

## Operation
- FSM states: RST, FETCH, EXEC, HALT.
- RST: entered on reset assertion. Leaves to FETCH on the first clock edge after `reset` deasserts.
- FETCH:
  - `imem_req`=1, `imem_addr`=`pc`, both held stable until `imem_ack`.
  - On `imem_ack`: latch `imem_rdata` into `instr` and go to EXEC.
- EXEC:
  - `instr_valid`=1.
  - If `stall`=1, stay in EXEC with `pc` and `instr` unchanged. All control inputs are ignored.
  - Otherwise, apply the first matching action in this priority order, then go to FETCH (HALT for `halt`):
    1. `halt`: go to HALT; `pc` is unchanged.
    2. `trap`: `mepc`←`pc`, `pc`←`TRAP_VEC`.
    3. `mret`: `pc`←`mepc`.
    4. `redirect`: if `redirect_target[1:0]`≠0, misaligned-target trap: `mepc`←`pc`, `pc`←`TRAP_VEC`. Otherwise `pc`←`redirect_target`.
    5. None of the above: `pc`←`pc`+4.
- HALT: absorbing state. `halted`=1, no requests issued. Exit only through reset.
- Control inputs (`redirect`, `trap`, `mret`, `halt`) are sampled only in EXEC. `imem_ack` is ignored outside FETCH.
- Arithmetic: `pc`+4 is modulo 2^32, so 32'hFFFF_FFFC → 32'h0000_0000. `pc[1:0]` is always 0.

## Timing
- Reset values: `pc`=`RESET_ADDR`, `mepc`=0, `instr`=0, `imem_req`=0, `instr_valid`=0, `halted`=0.
- `imem_addr` is combinationally equal to `pc`.
- `imem_req` and `instr_valid` are decoded from state with no combinational path from inputs.
- Minimum latency is 2 cycles per instruction: FETCH with same-cycle ack, then EXEC. Each cycle of `imem_ack` delay adds one cycle.
- First `imem_req` is asserted in the cycle after the first clock edge following reset release.
- `pc`, `mepc` and `instr` change only on the clock edge that leaves EXEC (pc/mepc) or FETCH (instr).
- Reset asserted mid-FETCH or mid-EXEC: immediately returns to reset values; the outstanding request is abandoned. A late `imem_ack` in RST is ignored.
- `stall` in the same cycle as `trap`/`redirect`: `stall` wins. Inputs are re-evaluated on the next EXEC cycle.

## Structure
- Package `pc_seq_pkg`:
  - state enum `pc_state_t` (RST, FETCH, EXEC, HALT);
  - `PC_INC`=4;
  - next-PC select enum (SEQ, REDIR, TRAP, MRET, HOLD).
- Sub-module `pc_reg`: 32-bit PC register with load enable and an asynchronous active-low reset to `RESET_ADDR`.
- FSM, next-PC mux and `mepc` register stay in `pc_sequencer`.

## Test plan
- Reset then sequential fetch, ack in the same cycle as req: addresses 0x0, 0x4, 0x8, one instruction every 2 cycles; `instr` matches the returned words.
- Ack delayed 3 cycles: `imem_req`/`imem_addr` stay stable for 4 cycles; exactly one EXEC follows.
- EXEC with `redirect`=1, target 0x40 → next `imem_addr`=0x40. Target 0x42 → `pc`=0x100, `mepc`=the redirecting PC.
- `trap` at `pc`=0x20 → `pc`=0x100, `mepc`=0x20. Later `mret` → fetch resumes at 0x20. `trap`+`redirect`+`stall` in the same cycle → held until `stall` drops, then trap taken.
- `RESET_ADDR`=0xFFFF_FFFC → second fetch at 0x0. `halt` → `halted`=1 and no further `imem_req`. Reset asserted mid-FETCH → all outputs return to reset values within the same cycle.
